fetch_unit: RTL and testbench
=============================

FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 The block SHALL have one clock and asynchronous active-low reset: clk, rst_n.
REQ-002 Parameter RESET_PC SHALL be declared with default 16'h0000 and meaning "first fetch address after reset".
REQ-003 Ports SHALL be:
- clk  in  1  clock, rising edge
- rst_n  in  1  async active-low reset
- branch_check  in  1  taken-branch strobe from ALU, sampled each clk
- branch_target  in  16  redirect address, valid when branch_check=1
- imem_req  out  1  instruction memory request
- imem_addr  out  16  word address of request
- imem_ack  in  1  memory response strobe; imem_rdata valid this cycle
- imem_rdata  in  16  fetched instruction word
- instr_valid  out  1  instr_out/instr_pc valid to decode
- instr_ready  in  1  decode accepts instruction
- instr_out  out  16  held instruction word
- instr_pc  out  16  address of instr_out

Function
REQ-004 All outputs SHALL be registered.
REQ-005 PC SHALL be 16-bit and word-addressed; sequential increment SHALL be +1 and SHALL wrap 16'hFFFF -> 16'h0000.
REQ-006 FSM states SHALL be IDLE, REQ, HOLD, DRAIN.
REQ-007 IDLE: imem_req=0, instr_valid=0; next state SHALL be REQ unconditionally.
REQ-008 REQ: imem_req=1, imem_addr=pc, held stable until imem_ack; ack SHALL be accepted in any cycle including the first REQ cycle.
REQ-009 REQ with imem_ack and no branch_check: instr_out<=imem_rdata, instr_pc<=pc, pc<=pc+1, instr_valid<=1, next state HOLD (ack-to-valid latency 1 clk).
REQ-010 HOLD: imem_req=0, instr_valid=1, instr_out/instr_pc stable; on instr_ready, instr_valid<=0 and next state REQ (request issued the following cycle).
REQ-011 Branch in REQ without imem_ack: target SHALL be latched, next state DRAIN; imem_addr SHALL NOT change.
REQ-012 DRAIN: imem_req=1 at original address until imem_ack; data on ack SHALL be discarded, pc<=latched target, next state REQ.
REQ-013 Branch in DRAIN: latched target SHALL be overwritten (latest branch wins).
REQ-014 Branch in REQ coincident with imem_ack: data SHALL be discarded, pc<=branch_target, instr_valid stays 0, next state REQ.
REQ-015 Branch in HOLD: instr_valid<=0 (squash), pc<=branch_target, next state REQ; branch SHALL win over a simultaneous instr_ready.
REQ-016 Branch in IDLE: pc<=branch_target, next state REQ.
REQ-017 instr_valid SHALL never assert for a word whose request preceded a taken branch.

Reset
REQ-018 While rst_n=0: state=IDLE, pc=RESET_PC, imem_req=0, imem_addr=16'h0000, instr_valid=0, instr_out=16'h0000, instr_pc=16'h0000, latched target=16'h0000.
REQ-019 Reset asserted mid-request SHALL abandon the request immediately; a late imem_ack after reset release SHALL be ignored unless the state is REQ or DRAIN.

Configuration
REQ-020 Macro FETCH_BRANCH_COUNT_EN SHALL control a taken-branch counter.
REQ-021 Defined: output branch_count (16-bit) SHALL count cycles with branch_check=1, saturate at 16'hFFFF, and reset to 0; undefined: the port and counter SHALL be absent, all other behaviour identical.

Verification
REQ-022 Reset release, RESET_PC=16'h0010, ack 1 clk after each req, instr_ready=1 -> imem_addr 0x0010, 0x0011, 0x0012; instr_pc matches.
REQ-023 pc=16'hFFFF fetch -> next imem_addr 16'h0000.
REQ-024 HOLD with instr_ready=0 for 5 clks -> instr_out/instr_pc stable, imem_req=0; then ready=1 -> valid drops next clk.
REQ-025 Branch to 16'h0200 during REQ, ack 3 clks later -> ack data discarded, no instr_valid, next imem_addr 16'h0200.
REQ-026 Branch to 16'h0300 in HOLD with instr_ready=1 same cycle -> instr_valid 0 next clk, next imem_addr 16'h0300.
REQ-027 With FETCH_BRANCH_COUNT_EN, 70000 branch strobes -> branch_count=16'hFFFF.

Source files
------------

// File: rtl/fetch_unit.sv
// fetch_unit: single-outstanding instruction fetch stage with branch redirect.
// Optional taken-branch counter: define FETCH_BRANCH_COUNT_EN for branch_count.
//
// Ports:
//   clk, rst_n          clock, async active-low reset
//   branch_check        taken-branch strobe, branch_target redirect address
//   imem_req/imem_addr  word-addressed instruction memory request
//   imem_ack/imem_rdata memory response strobe and data
//   instr_valid/ready   handshake towards decode
//   instr_out/instr_pc  held instruction word and its address
//   branch_count        saturating count of branch cycles (macro only)
module fetch_unit #(
  parameter logic [15:0] RESET_PC = 16'h0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        branch_check,
  input  logic [15:0] branch_target,
  output logic        imem_req,
  output logic [15:0] imem_addr,
  input  logic        imem_ack,
  input  logic [15:0] imem_rdata,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [15:0] instr_out,
  output logic [15:0] instr_pc
`ifdef FETCH_BRANCH_COUNT_EN
  ,
  output logic [15:0] branch_count
`endif
);

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    HOLD,
    DRAIN
  } state_t;

  state_t      state;
  logic [15:0] pc;
  logic [15:0] tgt;
  logic [15:0] pc_inc;
  logic [15:0] drain_pc;

  assign pc_inc = pc + 16'd1;

  // A branch arriving together with the drain ack is the newest one.
  assign drain_pc = branch_check ? branch_target : tgt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      pc          <= RESET_PC;
      tgt         <= 16'h0000;
      imem_req    <= 1'b0;
      imem_addr   <= 16'h0000;
      instr_valid <= 1'b0;
      instr_out   <= 16'h0000;
      instr_pc    <= 16'h0000;
    end else begin
      unique case (state)
        IDLE: begin
          state    <= REQ;
          imem_req <= 1'b1;
          if (branch_check) begin
            pc        <= branch_target;
            imem_addr <= branch_target;
          end else begin
            imem_addr <= pc;
          end
        end
        REQ: begin
          if (imem_ack && branch_check) begin
            // Response belongs to the squashed path; refetch at target.
            pc        <= branch_target;
            imem_addr <= branch_target;
          end else if (imem_ack) begin
            instr_out   <= imem_rdata;
            instr_pc    <= pc;
            pc          <= pc_inc;
            instr_valid <= 1'b1;
            imem_req    <= 1'b0;
            state       <= HOLD;
          end else if (branch_check) begin
            // Request must complete before redirecting.
            tgt   <= branch_target;
            state <= DRAIN;
          end
        end
        HOLD: begin
          if (branch_check) begin
            instr_valid <= 1'b0;
            pc          <= branch_target;
            imem_req    <= 1'b1;
            imem_addr   <= branch_target;
            state       <= REQ;
          end else if (instr_ready) begin
            instr_valid <= 1'b0;
            imem_req    <= 1'b1;
            imem_addr   <= pc;
            state       <= REQ;
          end
        end
        DRAIN: begin
          if (imem_ack) begin
            pc        <= drain_pc;
            imem_addr <= drain_pc;
            state     <= REQ;
          end else if (branch_check) begin
            tgt <= branch_target;
          end
        end
        default: begin
          state    <= IDLE;
          imem_req <= 1'b0;
        end
      endcase
    end
  end

`ifdef FETCH_BRANCH_COUNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      branch_count <= 16'h0000;
    end else if (branch_check && branch_count != 16'hFFFF) begin
      branch_count <= branch_count + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed scenarios plus randomized run against
// a stream-level model of the fetch unit.
module tb_fetch_unit;

  logic        clk;
  logic        rst_n;
  logic        branch_check;
  logic [15:0] branch_target;
  logic        imem_req;
  logic [15:0] imem_addr;
  logic        imem_ack;
  logic [15:0] imem_rdata;
  logic        instr_valid;
  logic        instr_ready;
  logic [15:0] instr_out;
  logic [15:0] instr_pc;
`ifdef FETCH_BRANCH_COUNT_EN
  logic [15:0] branch_count;
`endif

  int checks;
  int errors;

  fetch_unit #(.RESET_PC(16'h0010)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .branch_check (branch_check),
    .branch_target(branch_target),
    .imem_req     (imem_req),
    .imem_addr    (imem_addr),
    .imem_ack     (imem_ack),
    .imem_rdata   (imem_rdata),
    .instr_valid  (instr_valid),
    .instr_ready  (instr_ready),
    .instr_out    (instr_out),
    .instr_pc     (instr_pc)
`ifdef FETCH_BRANCH_COUNT_EN
    ,
    .branch_count (branch_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #3000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "simulation time limit reached");
  end

  function automatic logic [15:0] mem(input logic [15:0] a);
    logic [15:0] m;
    m = a * 16'h9E37;
    return m ^ 16'h5A5A;
  endfunction

  task automatic wait_req();
    bit ok;
    ok = 0;
    for (int i = 0; i < 20; i++) begin
      if (imem_req === 1'b1) begin
        ok = 1;
        break;
      end
      @(negedge clk);
    end
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL wait_req timeout imem_req=%b", imem_req);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if ({imem_req, instr_valid, imem_addr, instr_out, instr_pc} !== 50'd0) begin
      errors++;
      $display("FAIL reset_vals req=%b val=%b addr=%h out=%h pc=%h want all 0",
               imem_req, instr_valid, imem_addr, instr_out, instr_pc);
    end
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (imem_req !== 1'b1 || imem_addr !== 16'h0010 || instr_valid !== 1'b0) begin
      errors++;
      $display("FAIL first_req req=%b addr=%h val=%b want 1 0010 0",
               imem_req, imem_addr, instr_valid);
    end
  endtask

  task automatic test_sequential();
    logic [15:0] a;
    for (int k = 0; k < 3; k++) begin
      a = 16'h0010 + 16'(k);
      wait_req();
      checks++;
      if (imem_addr !== a) begin
        errors++;
        $display("FAIL seq_addr%0d got %h want %h", k, imem_addr, a);
      end
      @(negedge clk);
      imem_ack   = 1'b1;
      imem_rdata = mem(imem_addr);
      @(negedge clk);
      imem_ack = 1'b0;
      checks++;
      if (instr_valid !== 1'b1 || instr_pc !== a || instr_out !== mem(a)) begin
        errors++;
        $display("FAIL seq_word%0d val=%b pc=%h out=%h want 1 %h %h",
                 k, instr_valid, instr_pc, instr_out, a, mem(a));
      end
    end
  endtask

  task automatic test_wrap();
    wait_req();
    branch_check  = 1'b1;
    branch_target = 16'hFFFF;
    imem_ack      = 1'b1;
    imem_rdata    = mem(imem_addr);
    @(negedge clk);
    branch_check = 1'b0;
    imem_ack     = 1'b0;
    checks++;
    if (imem_req !== 1'b1 || imem_addr !== 16'hFFFF || instr_valid !== 1'b0) begin
      errors++;
      $display("FAIL br_ack_req req=%b addr=%h val=%b want 1 ffff 0",
               imem_req, imem_addr, instr_valid);
    end
    imem_ack   = 1'b1;
    imem_rdata = mem(16'hFFFF);
    @(negedge clk);
    imem_ack = 1'b0;
    checks++;
    if (instr_valid !== 1'b1 || instr_pc !== 16'hFFFF || instr_out !== mem(16'hFFFF)) begin
      errors++;
      $display("FAIL wrap_word val=%b pc=%h out=%h want 1 ffff %h",
               instr_valid, instr_pc, instr_out, mem(16'hFFFF));
    end
    @(negedge clk);
    checks++;
    if (imem_req !== 1'b1 || imem_addr !== 16'h0000) begin
      errors++;
      $display("FAIL wrap_addr req=%b addr=%h want 1 0000", imem_req, imem_addr);
    end
  endtask

  task automatic test_hold();
    logic [15:0] a;
    wait_req();
    a           = imem_addr;
    instr_ready = 1'b0;
    imem_ack    = 1'b1;
    imem_rdata  = mem(a);
    @(negedge clk);
    imem_ack = 1'b0;
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (instr_valid !== 1'b1 || imem_req !== 1'b0 ||
          instr_pc !== a || instr_out !== mem(a)) begin
        errors++;
        $display("FAIL hold_cyc%0d val=%b req=%b pc=%h out=%h want 1 0 %h %h",
                 i, instr_valid, imem_req, instr_pc, instr_out, a, mem(a));
      end
      @(negedge clk);
    end
    instr_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (instr_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== a + 16'd1) begin
      errors++;
      $display("FAIL hold_release val=%b req=%b addr=%h want 0 1 %h",
               instr_valid, imem_req, imem_addr, a + 16'd1);
    end
  endtask

  task automatic test_branch_req();
    logic [15:0] a;
    bit          seen;
    wait_req();
    a             = imem_addr;
    branch_check  = 1'b1;
    branch_target = 16'h0200;
    @(negedge clk);
    branch_check = 1'b0;
    checks++;
    if (imem_req !== 1'b1 || imem_addr !== a) begin
      errors++;
      $display("FAIL drain_addr req=%b addr=%h want 1 %h", imem_req, imem_addr, a);
    end
    seen = 0;
    for (int i = 0; i < 2; i++) begin
      seen |= instr_valid;
      @(negedge clk);
    end
    seen |= instr_valid;
    imem_ack   = 1'b1;
    imem_rdata = mem(a);
    @(negedge clk);
    imem_ack = 1'b0;
    seen |= instr_valid;
    checks++;
    if (seen || imem_req !== 1'b1 || imem_addr !== 16'h0200) begin
      errors++;
      $display("FAIL drain_redirect valid_seen=%b req=%b addr=%h want 0 1 0200",
               seen, imem_req, imem_addr);
    end
  endtask

  task automatic test_branch_hold();
    wait_req();
    imem_ack   = 1'b1;
    imem_rdata = mem(imem_addr);
    @(negedge clk);
    imem_ack = 1'b0;
    checks++;
    if (instr_valid !== 1'b1) begin
      errors++;
      $display("FAIL bh_valid got %b want 1", instr_valid);
    end
    branch_check  = 1'b1;
    branch_target = 16'h0300;
    instr_ready   = 1'b1;
    @(negedge clk);
    branch_check = 1'b0;
    checks++;
    if (instr_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 16'h0300) begin
      errors++;
      $display("FAIL bh_squash val=%b req=%b addr=%h want 0 1 0300",
               instr_valid, imem_req, imem_addr);
    end
  endtask

  task automatic test_drain_overwrite();
    wait_req();
    branch_check  = 1'b1;
    branch_target = 16'h1111;
    @(negedge clk);
    branch_target = 16'h2222;
    @(negedge clk);
    branch_check = 1'b0;
    imem_ack     = 1'b1;
    imem_rdata   = mem(imem_addr);
    @(negedge clk);
    imem_ack = 1'b0;
    checks++;
    if (imem_req !== 1'b1 || imem_addr !== 16'h2222 || instr_valid !== 1'b0) begin
      errors++;
      $display("FAIL drain_latest req=%b addr=%h val=%b want 1 2222 0",
               imem_req, imem_addr, instr_valid);
    end
  endtask

  task automatic test_branch_idle();
    rst_n = 1'b0;
    @(negedge clk);
    rst_n         = 1'b1;
    branch_check  = 1'b1;
    branch_target = 16'h0444;
    @(negedge clk);
    branch_check = 1'b0;
    checks++;
    if (imem_req !== 1'b1 || imem_addr !== 16'h0444) begin
      errors++;
      $display("FAIL idle_branch req=%b addr=%h want 1 0444", imem_req, imem_addr);
    end
  endtask

  task automatic test_reset_mid();
    wait_req();
    rst_n = 1'b0;
    #1;
    checks++;
    if (imem_req !== 1'b0 || imem_addr !== 16'h0000 || instr_valid !== 1'b0) begin
      errors++;
      $display("FAIL async_rst req=%b addr=%h val=%b want 0 0000 0",
               imem_req, imem_addr, instr_valid);
    end
    imem_ack   = 1'b1;
    imem_rdata = 16'hDEAD;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    imem_ack = 1'b0;
    checks++;
    if (imem_req !== 1'b1 || imem_addr !== 16'h0010 || instr_valid !== 1'b0) begin
      errors++;
      $display("FAIL late_ack req=%b addr=%h val=%b want 1 0010 0",
               imem_req, imem_addr, instr_valid);
    end
  endtask

  // Model: delivered words form the stream RESET_PC, +1, ... restarted at
  // every taken branch target; each word equals mem(its address).
  task automatic test_random();
    logic [15:0] exp_pc;
    logic [15:0] prev_addr;
    logic [15:0] prev_out;
    logic [15:0] prev_pc;
    bit          prev_req;
    bit          prev_ack;
    bit          prev_valid;
    bit          prev_ready;
    bit          prev_br;
    int          delivered;
    rst_n = 1'b0;
    @(negedge clk);
    rst_n      = 1'b1;
    exp_pc     = 16'h0010;
    prev_req   = 0;
    prev_ack   = 0;
    prev_valid = 0;
    prev_ready = 0;
    prev_br    = 0;
    prev_addr  = 16'h0;
    prev_out   = 16'h0;
    prev_pc    = 16'h0;
    delivered  = 0;
    for (int n = 0; n < 3000; n++) begin
      if (prev_req && !prev_ack) begin
        checks++;
        if (imem_req !== 1'b1 || imem_addr !== prev_addr) begin
          errors++;
          $display("FAIL rnd_req_stable n=%0d req=%b addr=%h want 1 %h",
                   n, imem_req, imem_addr, prev_addr);
        end
      end
      if (prev_valid && !prev_ready && !prev_br) begin
        checks++;
        if (instr_valid !== 1'b1 || instr_pc !== prev_pc || instr_out !== prev_out) begin
          errors++;
          $display("FAIL rnd_hold n=%0d val=%b pc=%h out=%h want 1 %h %h",
                   n, instr_valid, instr_pc, instr_out, prev_pc, prev_out);
        end
      end
      branch_check  = ($urandom_range(0, 9) == 0);
      branch_target = 16'($urandom);
      imem_ack      = ($urandom_range(0, 2) == 0);
      instr_ready   = ($urandom_range(0, 1) == 1);
      imem_rdata    = imem_req ? mem(imem_addr) : 16'($urandom);
      if (instr_valid === 1'b1 && instr_ready && !branch_check) begin
        checks++;
        delivered++;
        if (instr_pc !== exp_pc || instr_out !== mem(exp_pc)) begin
          errors++;
          $display("FAIL rnd_deliver n=%0d pc=%h out=%h want %h %h",
                   n, instr_pc, instr_out, exp_pc, mem(exp_pc));
        end
        exp_pc = exp_pc + 16'd1;
      end
      if (branch_check) exp_pc = branch_target;
      prev_req   = imem_req;
      prev_ack   = imem_ack;
      prev_addr  = imem_addr;
      prev_valid = instr_valid;
      prev_ready = instr_ready;
      prev_br    = branch_check;
      prev_out   = instr_out;
      prev_pc    = instr_pc;
      @(negedge clk);
    end
    branch_check = 1'b0;
    imem_ack     = 1'b0;
    instr_ready  = 1'b1;
    checks++;
    if (delivered < 100) begin
      errors++;
      $display("FAIL rnd_progress delivered=%0d want >=100", delivered);
    end
  endtask

`ifdef FETCH_BRANCH_COUNT_EN
  task automatic test_branch_count();
    rst_n = 1'b0;
    @(negedge clk);
    checks++;
    if (branch_count !== 16'h0000) begin
      errors++;
      $display("FAIL bc_reset got %h want 0000", branch_count);
    end
    rst_n         = 1'b1;
    branch_check  = 1'b1;
    branch_target = 16'h0040;
    repeat (100) @(negedge clk);
    checks++;
    if (branch_count !== 16'd100) begin
      errors++;
      $display("FAIL bc_100 got %0d want 100", branch_count);
    end
    repeat (69900) @(negedge clk);
    branch_check = 1'b0;
    @(negedge clk);
    checks++;
    if (branch_count !== 16'hFFFF) begin
      errors++;
      $display("FAIL bc_sat got %h want ffff", branch_count);
    end
  endtask
`endif

  initial begin
    checks        = 0;
    errors        = 0;
    rst_n         = 1'b0;
    branch_check  = 1'b0;
    branch_target = 16'h0000;
    imem_ack      = 1'b0;
    imem_rdata    = 16'h0000;
    instr_ready   = 1'b1;
    @(negedge clk);
    test_reset();
    test_sequential();
    test_wrap();
    test_hold();
    test_branch_req();
    test_branch_hold();
    test_drain_overwrite();
    test_branch_idle();
    test_reset_mid();
    test_random();
`ifdef FETCH_BRANCH_COUNT_EN
    test_branch_count();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
